ifmaps_stream_packer: RTL and testbench

//  Next-generation ifmaps input stage for the conv accelerator data path. Accepts an AXI4-Stream slave
//  and packs ELEM_WIDTH*MAC_NUM-bit MAC-array words from it. Buffers up to FIFO_DEPTH packed words
//  for the MAC array control. Adds byte-strobe masking, TLAST zero-pad flush, fill level, sync clear
//  and underflow error reporting.

---
 rtl/ifmaps_stream_packer_pkg.sv | 23 ++
 rtl/sync_fifo_wide.sv | 92 +++++++++
 rtl/ifmaps_stream_packer.sv | 124 ++++++++++++
 tb/tb_ifmaps_stream_packer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ifmaps_stream_packer_pkg.sv
// Shared accelerator data-path defaults, opcode constants and small elaboration helpers
// for the ifmaps stream packer and its FIFO.
package ifmaps_stream_packer_pkg;

    localparam int DEF_TDATA_WIDTH = 32;
    localparam int DEF_MAC_NUM     = 256;
    localparam int DEF_ELEM_WIDTH  = 5;
    localparam int DEF_FIFO_DEPTH  = 4;

    typedef enum logic [3:0] {
        INST_NOP          = 4'd0,
        INST_LOAD_IFMAPS  = 4'd1,
        INST_LOAD_WEIGHTS = 4'd2,
        INST_COMPUTE      = 4'd3,
        INST_STORE_PSUM   = 4'd4
    } inst_e;

    // Counter width that stays legal (>=1 bit) even for a single-entry range.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_wide.sv
// Register-array FIFO with registered level/full/empty and a registered head word
// that holds its last value while empty. Shared by the ifmaps and psum paths.
module sync_fifo_wide
    import ifmaps_stream_packer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = cnt_width(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [LVL_W-1:0] level_nxt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign rd_ptr_nxt = ptr_inc(rd_ptr);

    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + 1'b1;
        end else if (!do_push && do_pop) begin
            level_nxt = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Head register: refreshed only when a new word becomes the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            rdata  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            level <= level_nxt;
            full  <= (level_nxt == FULL_LVL);
            empty <= (level_nxt == '0);
            if (empty && do_push) begin
                rdata <= wdata;
            end else if (do_pop && level > ONE_LVL) begin
                rdata <= mem[rd_ptr_nxt];
            end else if (do_pop && do_push) begin
                rdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/ifmaps_stream_packer.sv
// AXI4-Stream to MAC-array word packer: strobe masking, beat assembly, optional TLAST
// zero-pad flush, frame/underflow status, feeding a small output FIFO.
module ifmaps_stream_packer
    import ifmaps_stream_packer_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int MAC_NUM              = DEF_MAC_NUM,
    parameter int ELEM_WIDTH           = DEF_ELEM_WIDTH,
    parameter int FIFO_DEPTH           = DEF_FIFO_DEPTH,
    localparam int OUT_W  = ELEM_WIDTH * MAC_NUM,
    localparam int STRB_W = C_S_AXIS_TDATA_WIDTH / 8,
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [STRB_W-1:0]               S_AXIS_TSTRB,
    input  logic                            S_AXIS_TLAST,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    input  logic                            pad_en,
    input  logic                            clear,
    input  logic                            MAC_read,
    output logic [OUT_W-1:0]                ifmaps_out,
    output logic                            fifo_empty,
    output logic                            fifo_full,
    output logic [LVL_W-1:0]                fifo_level,
    output logic                            frame_done,
    output logic                            underflow_err
);

    localparam int TW    = C_S_AXIS_TDATA_WIDTH;
    localparam int BEATS = OUT_W / TW;
    localparam int CNT_W = cnt_width(BEATS);

    if ((OUT_W % TW) != 0 || (TW % 8) != 0 || FIFO_DEPTH < 2) begin : g_bad_cfg
        $error("ifmaps_stream_packer: OUT_W must be a whole number of byte-multiple beats, FIFO_DEPTH>=2");
    end

    function automatic logic [TW-1:0] strobe_mask(input logic [TW-1:0] data,
                                                  input logic [STRB_W-1:0] strb);
        logic [TW-1:0] res;
        for (int b = 0; b < STRB_W; b++) begin
            res[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : 8'h00;
        end
        return res;
    endfunction

    logic             armed;
    logic [CNT_W-1:0] beat_cnt;
    logic [OUT_W-1:0] asm_word;
    logic [OUT_W-1:0] push_word;
    logic [TW-1:0]    beat_data;
    logic             accept;
    logic             last_beat;
    logic             push;

    // armed keeps TREADY low on the first cycle out of reset while staying register-driven.
    assign S_AXIS_TREADY = armed && !fifo_full && !clear;
    assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
    assign beat_data     = strobe_mask(S_AXIS_TDATA, S_AXIS_TSTRB);
    assign last_beat     = (beat_cnt == CNT_W'(BEATS - 1));
    assign push          = accept && (last_beat || (S_AXIS_TLAST && pad_en));

    // Lanes above the current beat are forced to zero, which also gives the pad flush
    // and guarantees no stale lanes from an aborted frame leak into a new word.
    always_comb begin
        push_word = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (k < int'(beat_cnt)) begin
                push_word[k*TW +: TW] = asm_word[k*TW +: TW];
            end else if (k == int'(beat_cnt)) begin
                push_word[k*TW +: TW] = beat_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            asm_word[beat_cnt*TW +: TW] <= beat_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed         <= 1'b0;
            beat_cnt      <= '0;
            frame_done    <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (clear) begin
                beat_cnt      <= '0;
                frame_done    <= 1'b0;
                underflow_err <= 1'b0;
            end else begin
                frame_done <= accept && S_AXIS_TLAST;
                if (MAC_read && fifo_empty) begin
                    underflow_err <= 1'b1;
                end
                if (accept) begin
                    beat_cnt <= push ? '0 : beat_cnt + 1'b1;
                end
            end
        end
    end

    sync_fifo_wide #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .wdata (push_word),
        .pop   (MAC_read),
        .rdata (ifmaps_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_ifmaps_stream_packer.sv
// Randomized + directed bench for ifmaps_stream_packer against a queue-based frame model.
module tb_ifmaps_stream_packer;

    localparam int TW    = 32;
    localparam int OUT_W = 128;
    localparam int BEATS = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [TW-1:0]    tdata;
    logic [3:0]       tstrb;
    logic             tlast, tvalid, pad_en, clear, mac_read;
    logic             tready;
    logic [OUT_W-1:0] ifmaps_out;
    logic             fifo_empty, fifo_full, frame_done, underflow_err;
    logic [1:0]       fifo_level;

    ifmaps_stream_packer #(
        .C_S_AXIS_TDATA_WIDTH (TW),
        .MAC_NUM              (16),
        .ELEM_WIDTH           (8),
        .FIFO_DEPTH           (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready),
        .pad_en        (pad_en),
        .clear         (clear),
        .MAC_read      (mac_read),
        .ifmaps_out    (ifmaps_out),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .fifo_level    (fifo_level),
        .frame_done    (frame_done),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: queue of complete words, list of beats of the open word.
    logic [OUT_W-1:0] mq[$];
    logic [TW-1:0]    pb[$];
    logic [OUT_W-1:0] m_head;
    logic             m_uf, m_fd, m_armed, last_acc;

    task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] masked(input logic [TW-1:0] d, input logic [3:0] s);
        logic [TW-1:0] r = '0;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic check_outputs();
        chk("ifmaps_out", ifmaps_out, m_head);
        chk("fifo_empty", fifo_empty, mq.size() == 0);
        chk("fifo_full", fifo_full, mq.size() == DEPTH);
        chk("fifo_level", fifo_level, mq.size());
        chk("frame_done", frame_done, m_fd);
        chk("underflow_err", underflow_err, m_uf);
    endtask

    // Called at a negedge; drives one cycle of inputs and advances the model over the posedge.
    task automatic step(input logic v, input logic [TW-1:0] d, input logic [3:0] s,
                        input logic l, input logic p, input logic c, input logic r);
        logic exp_rdy, acc;
        logic [OUT_W-1:0] w;
        tvalid = v; tdata = d; tstrb = s; tlast = l; pad_en = p; clear = c; mac_read = r;
        #1;
        exp_rdy = m_armed && !c && (mq.size() < DEPTH);
        chk("tready", tready, exp_rdy);
        acc = v && exp_rdy;
        last_acc = acc;
        @(posedge clk);
        if (c) begin
            mq.delete(); pb.delete(); m_uf = 1'b0; m_fd = 1'b0;
        end else begin
            if (r && mq.size() == 0) m_uf = 1'b1;
            else if (r) void'(mq.pop_front());
            m_fd = acc && l;
            if (acc) begin
                pb.push_back(masked(d, s));
                if (pb.size() == BEATS || (l && p)) begin
                    w = '0;
                    foreach (pb[i]) w[i*TW +: TW] = pb[i];
                    mq.push_back(w);
                    pb.delete();
                end
            end
        end
        m_armed = 1'b1;
        if (mq.size() > 0) m_head = mq[0];
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic r);
        step(1'b0, '0, 4'hF, 1'b0, 1'b0, 1'b0, r);
    endtask

    task automatic send(input logic [TW-1:0] d, input logic [3:0] s, input logic l, input logic p);
        for (int t = 0; t < 20; t++) begin
            step(1'b1, d, s, l, p, 1'b0, 1'b0);
            if (last_acc) return;
        end
        chk("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tvalid = 0; tdata = '0; tstrb = '0; tlast = 0; pad_en = 0; clear = 0; mac_read = 0;
        #1;
        mq.delete(); pb.delete();
        m_head = '0; m_uf = 0; m_fd = 0; m_armed = 0;
        chk("rst_tready", tready, 1'b0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        idle(1'b0);

        // 1: basic word, same-cycle visibility
        for (int i = 1; i <= 4; i++) send({4{4'(i), 4'(i)}}, 4'hF, 1'b0, 1'b0);
        chk("t1_word", ifmaps_out, 128'h44444444_33333333_22222222_11111111);
        chk("t1_level", fifo_level, 2'd1);
        idle(1'b1);

        // 2: fill to full, single pop reopens the stream
        for (int i = 0; i < 12; i++) step(1'b1, 32'hA000_0000 + i, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_full", fifo_full, 1'b1);
        chk("t2_tready_low", tready, 1'b0);
        idle(1'b1);
        for (int i = 0; i < 4; i++) send(32'hB000_0000 + i, 4'hF, 1'b0, 1'b0);
        chk("t2_level", fifo_level, 2'd2);
        idle(1'b1); idle(1'b1);

        // 3: TLAST pad flush, then TLAST without pad
        send(32'hAAAA0001, 4'hF, 1'b0, 1'b1);
        send(32'hBBBB0002, 4'hF, 1'b1, 1'b1);
        chk("t3_pad_word", ifmaps_out, {64'h0, 32'hBBBB0002, 32'hAAAA0001});
        chk("t3_frame_done", frame_done, 1'b1);
        idle(1'b1);
        chk("t3_fd_pulse", frame_done, 1'b0);
        send(32'hAAAA0001, 4'hF, 1'b0, 1'b0);
        send(32'hBBBB0002, 4'hF, 1'b1, 1'b0);
        chk("t3_nopad_level", fifo_level, 2'd0);
        send(32'hCCCC0003, 4'hF, 1'b0, 1'b0);
        send(32'hDDDD0004, 4'hF, 1'b0, 1'b0);
        chk("t3_cross_word", ifmaps_out, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);
        idle(1'b1);

        // 4: strobe masking
        send(32'hDEADBEEF, 4'b0101, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send(32'h0, 4'hF, 1'b0, 1'b0);
        chk("t4_strb", ifmaps_out[31:0], 32'h00AD00EF);
        idle(1'b1);

        // 5: underflow stickiness and clear of a partial word
        idle(1'b1);
        idle(1'b0);
        chk("t5_uf", underflow_err, 1'b1);
        send(32'h5555_0001, 4'hF, 1'b0, 1'b0);
        send(32'h5555_0002, 4'hF, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_uf_clr", underflow_err, 1'b0);
        for (int i = 1; i <= 4; i++) send(32'h6666_0000 + i, 4'hF, 1'b0, 1'b0);
        chk("t5_clean", ifmaps_out, 128'h66660004_66660003_66660002_66660001);
        idle(1'b1);

        // 6: async reset mid-frame
        for (int i = 0; i < 3; i++) send(32'h7777_0000 + i, 4'hF, 1'b0, 1'b0);
        do_reset();
        idle(1'b0);
        for (int i = 1; i <= 4; i++) send(32'h8888_0000 + i, 4'hF, 1'b0, 1'b0);
        chk("t6_clean", ifmaps_out, 128'h88880004_88880003_88880002_88880001);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom, 4'($urandom),
                     $urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 59) == 0,
                     $urandom_range(0, 2) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
